// File: rtl/boot_ram_arbiter.sv
// -----------------------------------------------------------------------------
// boot_ram_arbiter
//
// Boot sequencer and RAM write-port arbiter for the arlet6502 FPGA build.
// After reset the block waits for start, runs the RAM loader to preload the
// reset vector and program, holds the CPU in reset for RESET_HOLD cycles and
// then releases it. From then on the single RAM port belongs to the CPU,
// except when the host/debug requester takes it through a stall-and-grant
// handshake (CPU is stalled one DRAIN cycle before the host is granted).
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   start                 level: begin (or restart from RUN) the boot load
//   ldr_rst, ldr_load     loader reset (active high) and enable
//   ldr_done              loader finished
//   ldr_addr/data/we      loader RAM write request
//   cpu_addr/dout/we      CPU RAM write request
//   cpu_rst, cpu_rdy      CPU reset (active high) and ready (0 = stall)
//   host_req, host_gnt    host request (level) and grant
//   host_addr/data/we     host RAM write request
//   ram_addr/din/we       the shared RAM port
//   state_o               current state encoding
//   err                   sticky load-timeout flag
// -----------------------------------------------------------------------------
module boot_ram_arbiter #(
    parameter int RESET_HOLD   = 4,   // CPU reset cycles after load (>= 1)
    parameter int LOAD_TIMEOUT = 64   // max LOAD cycles before ERROR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        ldr_rst,
    output logic        ldr_load,
    input  logic        ldr_done,
    input  logic [15:0] ldr_addr,
    input  logic [7:0]  ldr_data,
    input  logic        ldr_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    output logic        cpu_rst,
    output logic        cpu_rdy,
    input  logic        host_req,
    output logic        host_gnt,
    input  logic [15:0] host_addr,
    input  logic [7:0]  host_data,
    input  logic        host_we,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_din,
    output logic        ram_we,
    output logic [2:0]  state_o,
    output logic        err
);

    // Counters are wide enough to hold their terminal values; the state
    // machine leaves LOAD/SETTLE before either could wrap.
    localparam int LD_W   = $clog2(LOAD_TIMEOUT + 1);
    localparam int HOLD_W = $clog2(RESET_HOLD + 1);

    localparam logic [LD_W-1:0]   LD_LAST   = LD_W'(LOAD_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_HOST   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [LD_W-1:0]     ld_cnt_q, ld_cnt_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic ldr_rst_q,  ldr_rst_d;
    logic ldr_load_q, ldr_load_d;
    logic cpu_rst_q,  cpu_rst_d;
    logic cpu_rdy_q,  cpu_rdy_d;
    logic host_gnt_q, host_gnt_d;
    logic err_q,      err_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ld_cnt_q   <= '0;
            hold_cnt_q <= '0;
            ldr_rst_q  <= 1'b1;
            ldr_load_q <= 1'b0;
            cpu_rst_q  <= 1'b1;
            cpu_rdy_q  <= 1'b0;
            host_gnt_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ld_cnt_q   <= ld_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            ldr_rst_q  <= ldr_rst_d;
            ldr_load_q <= ldr_load_d;
            cpu_rst_q  <= cpu_rst_d;
            cpu_rdy_q  <= cpu_rdy_d;
            host_gnt_q <= host_gnt_d;
            err_q      <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic (state and counters)
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                // ldr_done is only trusted once the loader has left reset.
                if (ldr_done && (ld_cnt_q != '0)) state_d = S_SETTLE;
                else if (ld_cnt_q == LD_LAST)     state_d = S_ERROR;
            end
            S_SETTLE: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                // A reload request outranks a host request.
                if (start)         state_d = S_LOAD;
                else if (host_req) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                state_d = host_req ? S_HOST : S_RUN;
            end
            S_HOST: begin
                if (!host_req) state_d = S_RUN;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Counters run only while the machine stays in their state and
        // restart from zero on every entry.
        ld_cnt_d = '0;
        if ((state_q == S_LOAD) && (state_d == S_LOAD)) ld_cnt_d = ld_cnt_q + 1'b1;

        hold_cnt_d = '0;
        if ((state_q == S_SETTLE) && (state_d == S_SETTLE)) hold_cnt_d = hold_cnt_q + 1'b1;
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Control outputs are registered decodes of the state being entered,
        // so each one changes on exactly the edge that makes the transition.
        ldr_rst_d  = (state_d != S_LOAD);
        ldr_load_d = (state_d == S_LOAD);
        cpu_rst_d  = !((state_d == S_RUN) || (state_d == S_DRAIN) || (state_d == S_HOST));
        cpu_rdy_d  = (state_d == S_RUN);
        host_gnt_d = (state_d == S_HOST);
        err_d      = err_q || (state_d == S_ERROR);

        // NOTE: the RAM port is a pure mux of the registered state, so it
        // needs no reset of its own: reset forces IDLE, which drives zeros.
        ram_addr = '0;
        ram_din  = '0;
        ram_we   = 1'b0;

        unique case (state_q)
            S_LOAD: begin
                ram_addr = ldr_addr;
                ram_din  = ldr_data;
                // Cycle 0 still sees the loader's reset outputs, and the
                // cycle that reports done carries no new write.
                ram_we   = ldr_we && (ld_cnt_q != '0) && !ldr_done;
            end
            S_RUN: begin
                ram_addr = cpu_addr;
                ram_din  = cpu_dout;
                ram_we   = cpu_we;
            end
            S_DRAIN: begin
                // CPU is stalled from this cycle; its bus is visible but
                // must not write.
                ram_addr = cpu_addr;
                ram_din  = cpu_dout;
                ram_we   = 1'b0;
            end
            S_HOST: begin
                ram_addr = host_addr;
                ram_din  = host_data;
                ram_we   = host_we;
            end
            default: begin
                ram_addr = '0;
                ram_din  = '0;
                ram_we   = 1'b0;
            end
        endcase
    end

    assign ldr_rst  = ldr_rst_q;
    assign ldr_load = ldr_load_q;
    assign cpu_rst  = cpu_rst_q;
    assign cpu_rdy  = cpu_rdy_q;
    assign host_gnt = host_gnt_q;
    assign err      = err_q;
    assign state_o  = state_q;

    // -------------------------------------------------------------------------
    // Invariants
    // -------------------------------------------------------------------------
    a_rdy_gnt_exclusive : assert property (@(posedge clk) disable iff (!rst_n)
        !(cpu_rdy_q && host_gnt_q));

    a_state_legal : assert property (@(posedge clk) disable iff (!rst_n)
        state_q != 3'd7);

    a_err_sticky : assert property (@(posedge clk) disable iff (!rst_n)
        err_q |=> err_q);

    a_error_holds_cpu : assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_ERROR) |-> (cpu_rst_q && !ldr_load_q && ldr_rst_q));

endmodule

// File: tb/tb_boot_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_boot_ram_arbiter
//
// Self-checking bench for boot_ram_arbiter. A behavioural loader replays a
// 23-entry boot image. Expected RAM writes are pushed into a scoreboard queue
// by the stimulus; a monitor pops one entry for every RAM write the DUT
// performs. Port ownership after boot follows the handshake rule: with a host
// request streak of k consecutive cycles, the CPU owns the port at k=0, the
// cycle at k=1 is the drain cycle, and the host owns the port for k>=2.
// -----------------------------------------------------------------------------
module tb_boot_ram_arbiter;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    localparam int N_IMG = 23;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        ldr_rst;
    logic        ldr_load;
    logic        ldr_done = 1'b0;
    logic [15:0] ldr_addr = '0;
    logic [7:0]  ldr_data = '0;
    logic        ldr_we   = 1'b0;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_rst;
    logic        cpu_rdy;
    logic        host_req;
    logic        host_gnt;
    logic [15:0] host_addr;
    logic [7:0]  host_data;
    logic        host_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic [2:0]  state_o;
    logic        err;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  wr_seen  = 0;
    int  streak   = 0;
    bit  ldr_stuck = 1'b0;
    wr_t exp_q[$];

    boot_ram_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ldr_rst   (ldr_rst),
        .ldr_load  (ldr_load),
        .ldr_done  (ldr_done),
        .ldr_addr  (ldr_addr),
        .ldr_data  (ldr_data),
        .ldr_we    (ldr_we),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .cpu_we    (cpu_we),
        .cpu_rst   (cpu_rst),
        .cpu_rdy   (cpu_rdy),
        .host_req  (host_req),
        .host_gnt  (host_gnt),
        .host_addr (host_addr),
        .host_data (host_data),
        .host_we   (host_we),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_we    (ram_we),
        .state_o   (state_o),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Boot image: reset vector FFFC/FFFD -> 8000, then 21 bytes at 2400..2414.
    function automatic wr_t img_entry(input int i);
        wr_t w;
        if (i == 0) begin
            w.addr = 16'hFFFC;
            w.data = 8'h00;
        end else if (i == 1) begin
            w.addr = 16'hFFFD;
            w.data = 8'h80;
        end else begin
            w.addr = 16'h2400 + 16'(i - 2);
            w.data = w.addr[7:0] + 8'h10;
        end
        return w;
    endfunction

    // Behavioural loader. Its reset outputs show a live write strobe to 0000,
    // and once finished it keeps the last write on the bus alongside done.
    logic [4:0] l_idx = '0;
    wr_t        l_ent;
    always @(posedge clk) begin
        if (ldr_rst === 1'b1) begin
            l_idx    <= '0;
            ldr_done <= 1'b0;
            ldr_we   <= 1'b1;
            ldr_addr <= '0;
            ldr_data <= '0;
        end else if (ldr_load === 1'b1) begin
            if (int'(l_idx) < N_IMG) begin
                l_ent     = img_entry(int'(l_idx));
                ldr_addr <= l_ent.addr;
                ldr_data <= l_ent.data;
                ldr_we   <= 1'b1;
                l_idx    <= l_idx + 5'd1;
            end else if (ldr_stuck) begin
                ldr_we   <= 1'b0;
            end else begin
                ldr_done <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the oldest expected write.
    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_t e;
            wr_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: actual=%0h/%0h expected=none (t=%0t)",
                         ram_addr, ram_din, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(ram_addr), 32'(e.addr));
                check("wr_data", 32'(ram_din), 32'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_bus();
        cpu_addr  = 16'($urandom);
        cpu_dout  = 8'($urandom);
        cpu_we    = 1'($urandom_range(0, 1));
        host_addr = 16'($urandom);
        host_data = 8'($urandom);
        host_we   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_reset_vals();
        check("rst_state",    32'(state_o),  0);
        check("rst_ldr_rst",  32'(ldr_rst),  1);
        check("rst_ldr_load", 32'(ldr_load), 0);
        check("rst_cpu_rst",  32'(cpu_rst),  1);
        check("rst_cpu_rdy",  32'(cpu_rdy),  0);
        check("rst_host_gnt", 32'(host_gnt), 0);
        check("rst_err",      32'(err),      0);
        check("rst_ram_we",   32'(ram_we),   0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din",  32'(ram_din),  0);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        host_req = 1'b0;
        cpu_we   = 1'b0;
        host_we  = 1'b0;
        tick();
        check_reset_vals();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        streak = 0;
        tick();
    endtask

    // Issue start (from IDLE or from a RUN cycle), expect the full image,
    // then the reset-hold window, ending on the first RUN cycle.
    task automatic do_load(input bit hreq);
        int  n;
        int  m;
        int  hold_start;
        bit  seen;
        bit  at_settle;
        hold_start = $urandom_range(1, 4);
        rand_bus();
        cpu_we   = 1'b0;
        host_we  = 1'b0;
        start    = 1'b1;
        host_req = hreq;
        for (int i = 0; i < N_IMG; i++) exp_q.push_back(img_entry(i));
        seen      = 1'b0;
        at_settle = 1'b0;
        for (n = 1; n <= 80; n++) begin
            tick();
            if (n == 1) begin
                check("load_enter_state", 32'(state_o),  1);
                check("load_cpu_rst",     32'(cpu_rst),  1);
                check("load_cpu_rdy",     32'(cpu_rdy),  0);
                check("load_ldr_load",    32'(ldr_load), 1);
                check("load_ldr_rst",     32'(ldr_rst),  0);
            end
            if (!seen && ram_we === 1'b1) begin
                seen = 1'b1;
                check("start_to_write", 32'(n), 2);
            end
            check("load_host_gnt", 32'(host_gnt), 0);
            if (state_o == 3'd2) begin
                at_settle = 1'b1;
                break;
            end
            if (n >= hold_start) start = 1'b0;
            rand_bus();
        end
        start = 1'b0;
        check("first_write_seen", 32'(seen), 1);
        check("reach_settle", 32'(at_settle), 1);
        check("settle_cpu_rst", 32'(cpu_rst), 1);
        m = 0;
        while (cpu_rst === 1'b1 && m < 10) begin
            rand_bus();
            tick();
            m++;
        end
        check("settle_len",   32'(m),       4);
        check("run_state0",   32'(state_o), 3);
        check("run_cpu_rdy0", 32'(cpu_rdy), 1);
        check("load_sb_empty", 32'(exp_q.size()), 0);
        streak = 0;
    endtask

    // One cycle after boot. Expected ownership comes from the request streak.
    task automatic run_cycle(input bit req, input bit dir,
                             input logic [15:0] ha, input logic [7:0] hd, input bit hw);
        wr_t w;
        check("run_cpu_rdy",  32'(cpu_rdy),  32'(streak == 0));
        check("run_host_gnt", 32'(host_gnt), 32'(streak >= 2));
        check("run_state",    32'(state_o),  (streak == 0) ? 3 : ((streak == 1) ? 4 : 5));
        check("run_cpu_rst",  32'(cpu_rst),  0);
        start    = 1'b0;
        host_req = req;
        rand_bus();
        if (dir) begin
            host_addr = ha;
            host_data = hd;
            host_we   = hw;
        end
        if (streak == 0 && cpu_we) begin
            w.addr = cpu_addr;
            w.data = cpu_dout;
            exp_q.push_back(w);
        end else if (streak >= 2 && host_we) begin
            w.addr = host_addr;
            w.data = host_data;
            exp_q.push_back(w);
        end
        tick();
        streak = req ? streak + 1 : 0;
    endtask

    initial begin
        int base;
        int n_load;
        rst_n     = 1'b0;
        start     = 1'b0;
        host_req  = 1'b0;
        cpu_addr  = '0;
        cpu_dout  = '0;
        cpu_we    = 1'b0;
        host_addr = '0;
        host_data = '0;
        host_we   = 1'b0;

        // Reset, then a full boot with the image loader.
        do_reset();
        do_load(1'b0);

        // Host handshake with a directed host write of 55 to E200.
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b1, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b1, 1'b1, 16'hE200, 8'h55, 1'b0);
        run_cycle(1'b1, 1'b1, 16'hE200, 8'h55, 1'b1);
        run_cycle(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);

        // Single-cycle host request: drain, then straight back to the CPU.
        run_cycle(1'b1, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);

        // Random request streaks with random CPU and host traffic.
        for (int i = 0; i < 300; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("run_sb_empty", 32'(exp_q.size()), 0);

        // start and host_req together in RUN: reload wins, host never granted.
        do_load(1'b1);
        for (int i = 0; i < 20; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);

        // Reset while the host owns the port.
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b1, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b1, 1'b0, '0, '0, 1'b0);
        check("host_before_rst", 32'(host_gnt), 1);
        cpu_we  = 1'b0;
        host_we = 1'b0;
        rst_n   = 1'b0;
        tick();
        check_reset_vals();
        check("host_rst_sb_empty", 32'(exp_q.size()), 0);
        rst_n    = 1'b1;
        host_req = 1'b0;
        tick();

        // Reset in the middle of a load, after ten image writes.
        base = wr_seen;
        start = 1'b1;
        cpu_we = 1'b0;
        for (int i = 0; i < N_IMG; i++) exp_q.push_back(img_entry(i));
        for (int n = 0; n < 60; n++) begin
            tick();
            start = 1'b0;
            rand_bus();
            if (wr_seen - base >= 10) break;
        end
        check("mid_load_writes", 32'(wr_seen - base), 10);
        check("mid_load_state", 32'(state_o), 1);
        rst_n = 1'b0;
        tick();
        check_reset_vals();
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        check("after_rst_idle", 32'(state_o), 0);

        // Loader that never reports done: timeout into ERROR.
        ldr_stuck = 1'b1;
        start = 1'b1;
        cpu_we = 1'b0;
        for (int i = 0; i < N_IMG; i++) exp_q.push_back(img_entry(i));
        n_load = 0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (state_o == 3'd1) n_load++;
            if (state_o == 3'd6) break;
            start = 1'($urandom_range(0, 1));
            rand_bus();
        end
        check("timeout_state",      32'(state_o),  6);
        check("timeout_load_cycles", 32'(n_load),  64);
        check("timeout_err",        32'(err),      1);
        check("timeout_cpu_rst",    32'(cpu_rst),  1);
        check("timeout_ldr_load",   32'(ldr_load), 0);
        check("timeout_ldr_rst",    32'(ldr_rst),  1);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            rand_bus();
            tick();
            check("error_hold_state", 32'(state_o), 6);
            check("error_hold_err",   32'(err),     1);
            check("error_cpu_rdy",    32'(cpu_rdy), 0);
        end
        check("timeout_sb_empty", 32'(exp_q.size()), 0);
        ldr_stuck = 1'b0;
        do_reset();

        // Recovery: a clean boot after the error.
        do_load(1'b0);
        for (int i = 0; i < 30; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        run_cycle(1'b0, 1'b0, '0, '0, 1'b0);
        check("final_sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
